// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register.
//   pipe_state_t : occupancy of a skid stage (EMPTY, BUSY = main valid, FULL = main + skid valid)
//   PIPE_MEMWB_W : default payload width, the MEM/WB field sum
//   memwb_t      : MEM/WB field layout so stages can pack/unpack the opaque payload
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      BUSY  = 2'b01,
      FULL  = 2'b10
   } pipe_state_t;

   localparam int unsigned PIPE_MEMWB_W = 104;

   typedef struct packed {
      logic        RegWrite;
      logic [1:0]  ResultSrc;
      logic [31:0] ALUResult;
      logic [31:0] ReadData;
      logic [4:0]  Rd;
      logic [31:0] PCPlus4;
   } memwb_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for pipeline statistics.
//   clk   : clock
//   reset : asynchronous active-high reset, clears the count
//   inc   : increment request for this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a 2-entry skid buffer and synchronous flush.
// The payload is opaque; stages pack their fields into it (see pipe_pkg::memwb_t).
// in_ready comes straight from a flop, and the skid entry absorbs the beat that
// arrives in the cycle the downstream stalls, so full throughput is kept.
//
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   flush              : synchronous squash of all held beats (highest priority)
//   in_valid/in_ready  : upstream handshake, in_ready registered
//   in_data            : upstream payload, DATA_W bits
//   out_valid/out_ready: downstream handshake
//   out_data           : downstream payload, direct register output
//   stall_cnt          : cycles with out_valid & !out_ready   (PIPE_STAT_EN only)
//   flush_cnt          : flushes that discarded held beats    (PIPE_STAT_EN only)
//
// Build option: define PIPE_STAT_EN to add the saturating statistic counters.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W        = PIPE_MEMWB_W,
   parameter bit          ZERO_ON_FLUSH = 1'b1,
   parameter int unsigned CNT_W         = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   pipe_state_t       state_q;
   logic              in_ready_q;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;

   logic in_xfer;
   logic out_xfer;

   assign out_valid = (state_q != EMPTY);
   assign in_ready  = in_ready_q;
   assign out_data  = main_q;

   assign in_xfer  = in_valid & in_ready_q;
   assign out_xfer = out_valid & out_ready;

   // in_ready_q is loaded with "next state is not FULL" alongside state_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         // An in_xfer this cycle is consumed and dropped; an out_xfer has already completed.
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
         if (ZERO_ON_FLUSH) begin
            main_q <= '0;
            skid_q <= '0;
         end
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_xfer) begin
                  main_q  <= in_data;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (in_xfer && out_xfer) begin
                  main_q <= in_data;
               end else if (in_xfer) begin
                  skid_q     <= in_data;
                  state_q    <= FULL;
                  in_ready_q <= 1'b0;
               end else if (out_xfer) begin
                  state_q <= EMPTY;
               end
            end
            FULL: begin
               if (out_xfer) begin
                  main_q     <= skid_q;
                  state_q    <= BUSY;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q    <= EMPTY;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

`ifdef PIPE_STAT_EN
   sat_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (out_valid & ~out_ready),
      .count(stall_cnt)
   );

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_flush_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (flush & (state_q != EMPTY)),
      .count(flush_cnt)
   );
`else
   // Counter width only matters when statistics are built in.
   if (CNT_W == 0) begin : g_no_stat
   end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a queue model of the held beats is
// compared with the DUT on every falling edge, plus literal spot checks.
module tb_pipe_stage_skid;

   localparam int unsigned DW       = 104;
   localparam int unsigned TB_CNT_W = 4;
   localparam bit          ZOF      = 1'b1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
`ifdef PIPE_STAT_EN
   logic [TB_CNT_W-1:0] stall_cnt;
   logic [TB_CNT_W-1:0] flush_cnt;
`endif

   pipe_stage_skid #(
      .DATA_W       (DW),
      .ZERO_ON_FLUSH(ZOF),
      .CNT_W        (TB_CNT_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
`ifdef PIPE_STAT_EN
      ,
      .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int errors = 0;

   // Model: FIFO of held beats (capacity 2) plus the value seen while empty.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] bubble = '0;
   int            stall_m = 0;
   int            flush_m = 0;
   logic [DW-1:0] got[$];

   localparam int CntMax = (1 << TB_CNT_W) - 1;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      mq.delete();
      bubble  = '0;
      stall_m = 0;
      flush_m = 0;
   endtask

   always @(posedge clk) begin
      if (!reset) begin
         automatic bit out_x = (mq.size() > 0) && out_ready;
         automatic bit in_x  = in_valid && (mq.size() < 2);
         if (mq.size() > 0 && !out_ready && stall_m < CntMax) stall_m++;
         if (flush && mq.size() > 0 && flush_m < CntMax) flush_m++;
         if (flush) begin
            if (ZOF) bubble = '0;
            else if (mq.size() > 0) bubble = mq[0];
            mq.delete();
         end else begin
            if (out_x) bubble = mq.pop_front();
            if (in_x) mq.push_back(in_data);
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         check("out_valid", {{(DW-1){1'b0}}, out_valid}, {{(DW-1){1'b0}}, mq.size() > 0});
         check("in_ready", {{(DW-1){1'b0}}, in_ready}, {{(DW-1){1'b0}}, mq.size() < 2});
         check("out_data", out_data, (mq.size() > 0) ? mq[0] : bubble);
`ifdef PIPE_STAT_EN
         check("stall_cnt", DW'(stall_cnt), DW'(stall_m));
         check("flush_cnt", DW'(flush_cnt), DW'(flush_m));
`endif
         if (out_valid && out_ready) got.push_back(out_data);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit accepted;

      // Reset then single beat
      model_clear();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_out_valid", DW'(out_valid), DW'(0));
      check("rst_in_ready", DW'(in_ready), DW'(1));
      check("rst_out_data", out_data, DW'(0));

      in_data = DW'(8'hA5); in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("single_valid", DW'(out_valid), DW'(1));
      check("single_data", out_data, DW'(8'hA5));
      step();
      check("single_empty", DW'(out_valid), DW'(0));
      check("single_ready", DW'(in_ready), DW'(1));

      // Streaming 1..100
      got.delete();
      for (int i = 1; i <= 100; i++) begin
         in_data = DW'(i); in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      repeat (2) step();
      check("stream_count", DW'(got.size()), DW'(100));
      for (int i = 0; i < got.size(); i++) begin
         if (got[i] !== DW'(i + 1)) check("stream_order", got[i], DW'(i + 1));
      end
      check("stream_last", (got.size() == 100) ? got[99] : '0, DW'(100));

      // Backpressure 7, 8, 9
      got.delete();
      out_ready = 1'b0;
      in_data = DW'(7); in_valid = 1'b1; step();
      in_data = DW'(8); step();
      in_data = DW'(9); step();
      check("bp_ready_low", DW'(in_ready), DW'(0));
      check("bp_hold_data", out_data, DW'(7));
      step();
      check("bp_still_7", out_data, DW'(7));
      out_ready = 1'b1;
      accepted = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (in_ready) begin
            step();
            accepted = 1'b1;
            break;
         end
         step();
      end
      in_valid = 1'b0;
      check("bp_accept_9", DW'(accepted), DW'(1));
      repeat (3) step();
      check("bp_count", DW'(got.size()), DW'(3));
      check("bp_first", (got.size() > 0) ? got[0] : '0, DW'(7));
      check("bp_second", (got.size() > 1) ? got[1] : '0, DW'(8));
      check("bp_third", (got.size() > 2) ? got[2] : '0, DW'(9));

      // Flush in FULL with a beat presented
      out_ready = 1'b0;
      in_data = DW'(3); in_valid = 1'b1; step();
      in_data = DW'(4); step();
      flush = 1'b1; in_data = DW'(5); step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_valid", DW'(out_valid), DW'(0));
      check("flush_ready", DW'(in_ready), DW'(1));
      check("flush_data", out_data, DW'(0));
      in_data = DW'(6); in_valid = 1'b1; out_ready = 1'b1; step();
      in_valid = 1'b0;
      check("post_flush_valid", DW'(out_valid), DW'(1));
      check("post_flush_data", out_data, DW'(6));
      step();

      // Asynchronous reset while FULL
      out_ready = 1'b0;
      in_data = DW'(1); in_valid = 1'b1; step();
      in_data = DW'(2); step();
      in_valid = 1'b0;
      check("pre_areset_ready", DW'(in_ready), DW'(0));
      @(negedge clk);
      #2 reset = 1'b1;
      model_clear();
      #1;
      check("areset_valid", DW'(out_valid), DW'(0));
      check("areset_ready", DW'(in_ready), DW'(1));
      check("areset_data", out_data, DW'(0));
      @(posedge clk);
      #1 reset = 1'b0;
      step();

`ifdef PIPE_STAT_EN
      // Statistics: stall saturation and flush counting
      out_ready = 1'b0;
      in_data = DW'(8'h11); in_valid = 1'b1; step();
      in_valid = 1'b0;
      repeat (20) step();
      check("stall_sat", DW'(stall_cnt), DW'(15));
      flush = 1'b1; step();
      flush = 1'b0;
      check("flush_busy", DW'(flush_cnt), DW'(1));
      flush = 1'b1; step();
      flush = 1'b0;
      check("flush_empty", DW'(flush_cnt), DW'(1));
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
